// File: rtl/bcd_mod_counter.sv
// bcd_mod_counter: cascadable BCD modulo counter for one clock-chain field
// (seconds .. years). Runtime upper limit, synchronous load, manual edit via
// active-low buttons and a combinational carry_out for the next stage.
// Optional macro BCD_EDIT_BLINK_EN enables a blinking 'blank' output while
// the field is being edited; without it 'blank' is tied low.

module bcd_mod_counter #(
    parameter int unsigned DIGITS = 2,
    localparam int unsigned W = 4 * DIGITS,
    parameter logic [W-1:0] MIN_VAL = '0,
    parameter logic [W-1:0] MAX_VAL = W'('h59),
    parameter logic [2:0] EDIT_SEL = 3'b001
) (
    input  logic         clk_1Hz,
    input  logic         rst_n,
    input  logic         carry_in,
    input  logic [W-1:0] lim_max,
    input  logic [2:0]   mode,
    input  logic         btn_up,
    input  logic         btn_down,
    input  logic         load_en,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value,
    output logic         carry_out,
    output logic         blank
);

    // Digit-wise BCD increment: 9 rolls to 0 and carries into the next digit.
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (c) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Digit-wise BCD decrement: 0 rolls to 9 and borrows from the next digit.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (b) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // True when every nibble is a legal decimal digit.
    function automatic logic bcd_digits_ok(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    logic [W-1:0] emax;
    logic         edit;
    logic         at_max;
    logic         at_min;
    logic         over_max;
    logic         load_ok;
    logic [W:0]   load_minus_min;
    logic [W:0]   min_minus_value;
    logic [W-1:0] inc_val;
    logic [W-1:0] dec_val;
    logic [W-1:0] next_value;

    // Effective limit, edit decode and the compare flags used by every rule.
    // Borrow-based MIN_VAL compares stay meaningful when MIN_VAL is zero.
    always_comb begin
        emax            = (lim_max < MAX_VAL) ? lim_max : MAX_VAL;
        edit            = (~mode == EDIT_SEL);
        at_max          = (value >= emax);
        over_max        = (value > emax);
        min_minus_value = {1'b0, MIN_VAL} - {1'b0, value};
        at_min          = ~min_minus_value[W];
        load_minus_min  = {1'b0, load_val} - {1'b0, MIN_VAL};
        load_ok         = bcd_digits_ok(load_val) && !load_minus_min[W]
                          && (load_val <= emax);
        inc_val         = at_max ? MIN_VAL : bcd_inc(value);
        dec_val         = at_min ? emax : bcd_dec(value);
    end

    // Next value by priority: load, edit buttons, clamp, count, hold.
    always_comb begin
        next_value = value;
        if (load_en) begin
            if (load_ok) next_value = load_val;
        end else if (edit && !btn_up) begin
            next_value = inc_val;
        end else if (edit && !btn_down) begin
            next_value = dec_val;
        end else if (over_max) begin
            next_value = emax;
        end else if (!edit && carry_in) begin
            next_value = inc_val;
        end
    end

    // Field value register.
    always_ff @(posedge clk_1Hz or negedge rst_n) begin
        if (!rst_n) value <= MIN_VAL;
        else        value <= next_value;
    end

    // Wrap request to the next stage, rippling within the same cycle.
    assign carry_out = carry_in & ~edit & ~load_en & at_max;

`ifdef BCD_EDIT_BLINK_EN
    logic blank_q;

    // Blink while editing; stay visible on a button step and after exit.
    always_ff @(posedge clk_1Hz or negedge rst_n) begin
        if (!rst_n)                          blank_q <= 1'b0;
        else if (edit && btn_up && btn_down) blank_q <= ~blank_q;
        else                                 blank_q <= 1'b0;
    end

    assign blank = blank_q;
`else
    assign blank = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Self-checking bench for bcd_mod_counter: a minute-style instance
// (00..59) and a day-style instance (01..31) share stimulus and are
// compared every cycle against a decimal-integer reference model.

module tb_bcd_mod_counter;

    logic       clk_1Hz = 1'b0;
    logic       rst_n;
    logic       carry_in;
    logic [2:0] mode;
    logic       btn_up;
    logic       btn_down;
    logic       load_en;
    logic [7:0] load_val;
    logic [7:0] m_lim;
    logic [7:0] d_lim;
    logic [7:0] m_value;
    logic [7:0] d_value;
    logic       m_carry;
    logic       d_carry;
    logic       m_blank;
    logic       d_blank;

    int checks   = 0;
    int failures = 0;

    // Reference model state (decimal integers, blink flags)
    int mv;
    int dv;
    bit mb;
    bit db;

    localparam logic [2:0] M_SEL = 3'b001;
    localparam logic [2:0] D_SEL = 3'b010;

    always #5 clk_1Hz = ~clk_1Hz;

    bcd_mod_counter #(
        .DIGITS(2), .MIN_VAL(8'h00), .MAX_VAL(8'h59), .EDIT_SEL(M_SEL)
    ) u_min (
        .clk_1Hz(clk_1Hz), .rst_n(rst_n), .carry_in(carry_in), .lim_max(m_lim),
        .mode(mode), .btn_up(btn_up), .btn_down(btn_down), .load_en(load_en),
        .load_val(load_val), .value(m_value), .carry_out(m_carry), .blank(m_blank)
    );

    bcd_mod_counter #(
        .DIGITS(2), .MIN_VAL(8'h01), .MAX_VAL(8'h31), .EDIT_SEL(D_SEL)
    ) u_day (
        .clk_1Hz(clk_1Hz), .rst_n(rst_n), .carry_in(carry_in), .lim_max(d_lim),
        .mode(mode), .btn_up(btn_up), .btn_down(btn_down), .load_en(load_en),
        .load_val(load_val), .value(d_value), .carry_out(d_carry), .blank(d_blank)
    );

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic int from_bcd(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Field rules in plain decimal arithmetic.
    function automatic int mdl_next(input int v, input int mn, input int mx,
                                    input logic [7:0] lim, input bit ed,
                                    input bit ci, input bit up_n, input bit dn_n,
                                    input bit ld, input logic [7:0] lv);
        int emax;
        int lvd;
        emax = min2(mx, from_bcd(lim));
        if (ld) begin
            lvd = from_bcd(lv);
            if (lv[7:4] <= 4'd9 && lv[3:0] <= 4'd9 && lvd >= mn && lvd <= emax)
                return lvd;
            return v;
        end
        if (ed && !up_n) return (v >= emax) ? mn : v + 1;
        if (ed && !dn_n) return (v <= mn) ? emax : v - 1;
        if (v > emax) return emax;
        if (!ed && ci) return (v >= emax) ? mn : v + 1;
        return v;
    endfunction

    function automatic bit mdl_carry(input int v, input int mx, input logic [7:0] lim,
                                     input bit ed, input bit ci, input bit ld);
        return ci && !ed && !ld && (v >= min2(mx, from_bcd(lim)));
    endfunction

    function automatic bit mdl_blank(input bit b, input bit ed, input bit up_n, input bit dn_n);
`ifdef BCD_EDIT_BLINK_EN
        if (ed && up_n && dn_n) return !b;
        return 1'b0;
`else
        return 1'b0 & b & ed & up_n & dn_n;
`endif
    endfunction

    // One clock with current inputs: check carry before the edge, state after.
    task automatic step();
        bit me, de, mc, dc;
        int mn, dn;
        me = (~mode == M_SEL);
        de = (~mode == D_SEL);
        #1;
        mc = mdl_carry(mv, 59, m_lim, me, carry_in, load_en);
        dc = mdl_carry(dv, 31, d_lim, de, carry_in, load_en);
        checks++;
        if (m_carry !== mc) begin
            failures++;
            $display("FAIL min_carry t=%0t got=%b exp=%b", $time, m_carry, mc);
        end
        checks++;
        if (d_carry !== dc) begin
            failures++;
            $display("FAIL day_carry t=%0t got=%b exp=%b", $time, d_carry, dc);
        end
        mn = mdl_next(mv, 0, 59, m_lim, me, carry_in, btn_up, btn_down, load_en, load_val);
        dn = mdl_next(dv, 1, 31, d_lim, de, carry_in, btn_up, btn_down, load_en, load_val);
        mb = mdl_blank(mb, me, btn_up, btn_down);
        db = mdl_blank(db, de, btn_up, btn_down);
        @(posedge clk_1Hz);
        #1;
        mv = mn;
        dv = dn;
        checks++;
        if (m_value !== to_bcd(mv)) begin
            failures++;
            $display("FAIL min_value t=%0t got=%h exp=%h", $time, m_value, to_bcd(mv));
        end
        checks++;
        if (d_value !== to_bcd(dv)) begin
            failures++;
            $display("FAIL day_value t=%0t got=%h exp=%h", $time, d_value, to_bcd(dv));
        end
        checks++;
        if (m_blank !== mb || d_blank !== db) begin
            failures++;
            $display("FAIL blank t=%0t got=%b%b exp=%b%b", $time, m_blank, d_blank, mb, db);
        end
    endtask

    task automatic idle_inputs();
        carry_in = 1'b0;
        mode     = 3'b111;
        btn_up   = 1'b1;
        btn_down = 1'b1;
        load_en  = 1'b0;
        load_val = 8'h00;
        m_lim    = 8'h59;
        d_lim    = 8'h31;
    endtask

    task automatic do_load(input logic [7:0] v);
        load_en  = 1'b1;
        load_val = v;
        step();
        load_en  = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        mv = 0; dv = 1; mb = 1'b0; db = 1'b0;
        @(negedge clk_1Hz);
        @(negedge clk_1Hz);
        checks++;
        if (m_value !== 8'h00 || d_value !== 8'h01 || m_blank !== 1'b0 || d_blank !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got=%h/%h blank=%b%b exp=00/01 blank=00",
                     m_value, d_value, m_blank, d_blank);
        end
        rst_n = 1'b1;
        @(posedge clk_1Hz);
        #1;
    endtask

    task automatic test_cascade();
        do_load(8'h59);
        carry_in = 1'b1;
        #1;
        checks++;
        if (m_carry !== 1'b1) begin
            failures++;
            $display("FAIL cascade_carry_at_max got=%b exp=1", m_carry);
        end
        step();
        checks++;
        if (m_value !== 8'h00 || m_carry !== 1'b0) begin
            failures++;
            $display("FAIL cascade_wrap got=%h/%b exp=00/0", m_value, m_carry);
        end
        carry_in = 1'b0;
    endtask

    task automatic test_ripple();
        do_load(8'h09);
        carry_in = 1'b1;
        step();
        carry_in = 1'b0;
        checks++;
        if (m_value !== 8'h10 || d_value !== 8'h10) begin
            failures++;
            $display("FAIL ripple_09 got=%h/%h exp=10/10", m_value, d_value);
        end
        do_load(8'h19);
        carry_in = 1'b1;
        step();
        carry_in = 1'b0;
        checks++;
        if (m_value !== 8'h20 || d_value !== 8'h20) begin
            failures++;
            $display("FAIL ripple_19 got=%h/%h exp=20/20", m_value, d_value);
        end
    endtask

    task automatic test_edit();
        mode = ~M_SEL;
        do_load(8'h00);
        btn_down = 1'b0;
        step();
        btn_down = 1'b1;
        checks++;
        if (m_value !== 8'h59) begin
            failures++;
            $display("FAIL edit_down_wrap got=%h exp=59", m_value);
        end
        btn_up = 1'b0;
        step();
        btn_up = 1'b1;
        checks++;
        if (m_value !== 8'h00) begin
            failures++;
            $display("FAIL edit_up_wrap got=%h exp=00", m_value);
        end
        do_load(8'h05);
        btn_up = 1'b0;
        btn_down = 1'b0;
        step();
        btn_up = 1'b1;
        btn_down = 1'b1;
        checks++;
        if (m_value !== 8'h06) begin
            failures++;
            $display("FAIL edit_both_up_wins got=%h exp=06", m_value);
        end
        do_load(8'h59);
        carry_in = 1'b1;
        #1;
        checks++;
        if (m_carry !== 1'b0) begin
            failures++;
            $display("FAIL edit_no_carry got=%b exp=0", m_carry);
        end
        step();
        carry_in = 1'b0;
        mode = 3'b111;
    endtask

    task automatic test_limit();
        do_load(8'h31);
        d_lim = 8'h28;
        step();
        checks++;
        if (d_value !== 8'h28) begin
            failures++;
            $display("FAIL limit_clamp got=%h exp=28", d_value);
        end
        carry_in = 1'b1;
        #1;
        checks++;
        if (d_carry !== 1'b1) begin
            failures++;
            $display("FAIL limit_carry got=%b exp=1", d_carry);
        end
        step();
        carry_in = 1'b0;
        checks++;
        if (d_value !== 8'h01) begin
            failures++;
            $display("FAIL limit_wrap got=%h exp=01", d_value);
        end
        mode = ~D_SEL;
        btn_down = 1'b0;
        step();
        btn_down = 1'b1;
        mode = 3'b111;
        checks++;
        if (d_value !== 8'h28) begin
            failures++;
            $display("FAIL limit_edit_down got=%h exp=28", d_value);
        end
        d_lim = 8'h31;
    endtask

    task automatic test_load();
        do_load(8'h45);
        checks++;
        if (m_value !== 8'h45) begin
            failures++;
            $display("FAIL load_ok got=%h exp=45", m_value);
        end
        do_load(8'h4A);
        checks++;
        if (m_value !== 8'h45) begin
            failures++;
            $display("FAIL load_bad_digit got=%h exp=45", m_value);
        end
        do_load(8'h60);
        checks++;
        if (m_value !== 8'h45) begin
            failures++;
            $display("FAIL load_over_max got=%h exp=45", m_value);
        end
        mode = ~M_SEL;
        btn_up = 1'b0;
        do_load(8'h12);
        btn_up = 1'b1;
        mode = 3'b111;
        checks++;
        if (m_value !== 8'h12) begin
            failures++;
            $display("FAIL load_beats_edit got=%h exp=12", m_value);
        end
    endtask

    task automatic test_async_reset();
        bit exp_seq [4];
        exp_seq = '{1'b1, 1'b0, 1'b1, 1'b0};
        do_load(8'h33);
        mode = ~M_SEL;
        for (int i = 0; i < 4; i++) begin
            step();
`ifdef BCD_EDIT_BLINK_EN
            checks++;
            if (m_blank !== exp_seq[i]) begin
                failures++;
                $display("FAIL blink_seq[%0d] got=%b exp=%b", i, m_blank, exp_seq[i]);
            end
`endif
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (m_value !== 8'h00 || d_value !== 8'h01 || m_blank !== 1'b0 || d_blank !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got=%h/%h blank=%b%b exp=00/01 blank=00",
                     m_value, d_value, m_blank, d_blank);
        end
        mv = 0; dv = 1; mb = 1'b0; db = 1'b0;
        mode = 3'b111;
        #1;
        rst_n = 1'b1;
        @(posedge clk_1Hz);
        #1;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            carry_in = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 4))
                0, 1:    mode = 3'b111;
                2:       mode = ~M_SEL;
                3:       mode = ~D_SEL;
                default: mode = 3'($urandom);
            endcase
            btn_up   = ($urandom_range(0, 2) != 0);
            btn_down = ($urandom_range(0, 2) != 0);
            load_en  = ($urandom_range(0, 7) == 0);
            load_val = ($urandom_range(0, 1) == 0) ? to_bcd($urandom_range(0, 99)) : 8'($urandom);
            if ($urandom_range(0, 9) == 0)
                m_lim = ($urandom_range(0, 3) == 0) ? 8'h99 : to_bcd($urandom_range(0, 59));
            if ($urandom_range(0, 9) == 0)
                d_lim = to_bcd($urandom_range(28, 31));
            step();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_cascade();
        test_ripple();
        test_edit();
        test_limit();
        test_load();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
